quad_decoder: RTL and testbench

- Quadrature (A/B) decoder that converts two asynchronous encoder phases into up/down count events.
- Drives an internal N-bit wrap-around up/down counter with synchronous clear, load, and max/min wrap ticks.
- Sits on the receive side of an encoder interface, in front of position/speed logic. Replaces externally driven direction control with direction decoded from the phase relationship.

---
 rtl/quad_decoder.sv | 232 +++++++++++++++++++++++
 tb/tb_quad_decoder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature A/B decoder driving a wrap-around up/down position counter
module quad_decoder #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enc_a,
    input  logic         enc_b,
    input  logic         enable,
    input  logic         syn_clr,
    input  logic         load,
    input  logic [N-1:0] in_num,
    output logic [N-1:0] count,
    output logic         dir,
    output logic         step,
    output logic         max_tick,
    output logic         min_tick,
    output logic         err
);

    // Filter counter must be able to hold FILT_LEN while saturating during init.
    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] FILT_MAX  = CW'(FILT_LEN);
    localparam logic [CW-1:0] FILT_LAST = CW'(FILT_LEN - 1);

    typedef enum logic {
        MODE_INIT  = 1'b0,
        MODE_TRACK = 1'b1
    } mode_t;

    // Synchroniser chains; the last stage is the only one the filter looks at.
    logic [SYNC_STAGES-1:0] a_sync_q;
    logic [SYNC_STAGES-1:0] b_sync_q;
    logic                   a_smp;
    logic                   b_smp;

    // Filter state per phase.
    logic          a_filt_q, a_filt_d;
    logic          b_filt_q, b_filt_d;
    logic [CW-1:0] a_cnt_q,  a_cnt_d;
    logic [CW-1:0] b_cnt_q,  b_cnt_d;
    logic          a_lvl_nx, b_lvl_nx;
    logic [CW-1:0] a_cnt_nx, b_cnt_nx;

    // Decoder state: last filtered {A,B} the decoder has consumed.
    mode_t      mode_q, mode_d;
    logic [1:0] st_q, st_d;
    logic       enter_track;

    // Decoded events.
    logic       dec_up;
    logic       dec_dn;
    logic       dec_err;

    // Counter and registered outputs.
    logic [N-1:0] count_q, count_d;
    logic         dir_q,   dir_d;
    logic         step_q,  step_d;
    logic         max_q,   max_d;
    logic         min_q,   min_d;
    logic         err_q,   err_d;

    // One filter step. In init mode the counter counts consecutive identical
    // samples (saturating at FILT_LEN) and the level simply follows the input;
    // in track mode it counts consecutive samples that differ from the level.
    function automatic logic [CW:0] filt_next(
        input logic          track,
        input logic          lvl,
        input logic          smp,
        input logic [CW-1:0] cnt
    );
        logic          lvl_n;
        logic [CW-1:0] cnt_n;
        lvl_n = lvl;
        cnt_n = cnt;
        if (!track) begin
            if (smp == lvl) begin
                cnt_n = (cnt == FILT_MAX) ? cnt : cnt + 1'b1;
            end else begin
                lvl_n = smp;
                cnt_n = CW'(1);
            end
        end else begin
            if (smp != lvl) begin
                if (cnt == FILT_LAST) begin
                    lvl_n = smp;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end else begin
                cnt_n = '0;
            end
        end
        return {lvl_n, cnt_n};
    endfunction

    assign a_smp = a_sync_q[SYNC_STAGES-1];
    assign b_smp = b_sync_q[SYNC_STAGES-1];

    // Synchronise both asynchronous phases into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
        end else begin
            a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], enc_a};
            b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], enc_b};
        end
    end

    // Per-phase filter next state; counters restart when tracking begins.
    always_comb begin
        {a_lvl_nx, a_cnt_nx} = filt_next(mode_q == MODE_TRACK, a_filt_q, a_smp, a_cnt_q);
        {b_lvl_nx, b_cnt_nx} = filt_next(mode_q == MODE_TRACK, b_filt_q, b_smp, b_cnt_q);
        enter_track = (mode_q == MODE_INIT) && (a_cnt_nx == FILT_MAX) && (b_cnt_nx == FILT_MAX);
        a_filt_d = a_lvl_nx;
        b_filt_d = b_lvl_nx;
        a_cnt_d  = enter_track ? '0 : a_cnt_nx;
        b_cnt_d  = enter_track ? '0 : b_cnt_nx;
    end

    // Filter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_filt_q <= 1'b0;
            b_filt_q <= 1'b0;
            a_cnt_q  <= '0;
            b_cnt_q  <= '0;
        end else begin
            a_filt_q <= a_filt_d;
            b_filt_q <= b_filt_d;
            a_cnt_q  <= a_cnt_d;
            b_cnt_q  <= b_cnt_d;
        end
    end

    // Decoder state register: init/track mode plus the consumed {A,B} pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_INIT;
            st_q   <= 2'b00;
        end else begin
            mode_q <= mode_d;
            st_q   <= st_d;
        end
    end

    // Decoder next state: during init the pair is loaded straight from the
    // settled samples so the first tracked cycle never sees a transition.
    always_comb begin
        mode_d = mode_q;
        st_d   = st_q;
        if (mode_q == MODE_INIT) begin
            st_d = {a_filt_d, b_filt_d};
            if (enter_track) begin
                mode_d = MODE_TRACK;
            end
        end else begin
            st_d = {a_filt_q, b_filt_q};
        end
    end

    // Decoder outputs: classify the transition from st_q to the filtered pair.
    always_comb begin
        dec_up  = 1'b0;
        dec_dn  = 1'b0;
        dec_err = 1'b0;
        if (mode_q == MODE_TRACK) begin
            case ({st_q, a_filt_q, b_filt_q})
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: dec_up = 1'b1;
                4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: dec_dn = 1'b1;
                4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: dec_err = 1'b1;
                default: ;
            endcase
        end
    end

    // Counter next state: clear beats load beats a decoded step.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        max_d   = 1'b0;
        min_d   = 1'b0;
        err_d   = dec_err;
        if (syn_clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = in_num;
        end else if (enable && dec_up) begin
            count_d = count_q + 1'b1;
            dir_d   = 1'b1;
            step_d  = 1'b1;
            max_d   = (count_q == {N{1'b1}});
        end else if (enable && dec_dn) begin
            count_d = count_q - 1'b1;
            dir_d   = 1'b0;
            step_d  = 1'b1;
            min_d   = (count_q == '0);
        end
    end

    // Counter and pulse output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            max_q   <= 1'b0;
            min_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            max_q   <= max_d;
            min_q   <= min_d;
            err_q   <= err_d;
        end
    end

    assign count    = count_q;
    assign dir      = dir_q;
    assign step     = step_q;
    assign max_tick = max_q;
    assign min_tick = min_q;
    assign err      = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - scoreboard bench for quad_decoder
module tb_quad_decoder;

    localparam int N = 8;
    localparam int LAT = 6; // drive at negedge c, capture at edge c+1, update at edge c+1+5

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enc_a, enc_b;
    logic         enable, syn_clr, load;
    logic [N-1:0] in_num;
    logic [N-1:0] count;
    logic         dir, step, max_tick, min_tick, err;

    typedef struct {
        int           cyc;
        logic         step;
        logic         dir;
        logic         maxt;
        logic         mint;
        logic         err;
        logic [N-1:0] count;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  cyc = 0;
    int  n_pass = 0;
    int  n_total = 0;

    quad_decoder #(.N(N), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .enable   (enable),
        .syn_clr  (syn_clr),
        .load     (load),
        .in_num   (in_num),
        .count    (count),
        .dir      (dir),
        .step     (step),
        .max_tick (max_tick),
        .min_tick (min_tick),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n && (step || err || max_tick || min_tick)) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event cyc=%0d count=%0h dir=%0b step=%0b max=%0b min=%0b err=%0b",
                         cyc, count, dir, step, max_tick, min_tick, err);
            end else begin
                mon_e = exp_q.pop_front();
                if ({step, dir, max_tick, min_tick, err, count} ===
                    {mon_e.step, mon_e.dir, mon_e.maxt, mon_e.mint, mon_e.err, mon_e.count}) begin
                    n_pass++;
                end else begin
                    $display("FAIL event got step=%0b dir=%0b max=%0b min=%0b err=%0b count=%0h want step=%0b dir=%0b max=%0b min=%0b err=%0b count=%0h",
                             step, dir, max_tick, min_tick, err, count,
                             mon_e.step, mon_e.dir, mon_e.maxt, mon_e.mint, mon_e.err, mon_e.count);
                end
                n_total++;
                if (cyc == mon_e.cyc) n_pass++;
                else $display("FAIL latency got cyc=%0d want cyc=%0d", cyc, mon_e.cyc);
            end
        end
    end

    task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%0h want=%0h", name, got, want);
    endtask

    // Drive a phase pair and, if an event is due, push its expected response.
    task automatic drive(input logic a, input logic b, input logic ev,
                         input logic e_step, input logic e_dir, input logic e_max,
                         input logic e_min, input logic e_err, input logic [N-1:0] e_cnt);
        ev_t e;
        enc_a = a;
        enc_b = b;
        if (ev) begin
            e.cyc   = cyc + LAT;
            e.step  = e_step;
            e.dir   = e_dir;
            e.maxt  = e_max;
            e.mint  = e_min;
            e.err   = e_err;
            e.count = e_cnt;
            exp_q.push_back(e);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic do_load(input logic [N-1:0] v);
        load   = 1'b1;
        in_num = v;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst_n = 1'b0; enc_a = 1'b1; enc_b = 1'b1;
        enable = 1'b1; syn_clr = 1'b0; load = 1'b0; in_num = '0;
        repeat (3) @(negedge clk);
        check("reset_count", count, 8'h00);
        check("reset_flags", {3'b0, dir, step, max_tick, min_tick, err}, 8'h00);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("init_11_count", count, 8'h00);

        // Reset again while the phases move, then initialise at 00.
        enc_a = 1'b0; enc_b = 1'b0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("init_00_count", count, 8'h00);

        // Four up edges.
        drive(1, 0, 1, 1, 1, 0, 0, 0, 8'h01);
        drive(1, 1, 1, 1, 1, 0, 0, 0, 8'h02);
        drive(0, 1, 1, 1, 1, 0, 0, 0, 8'h03);
        drive(0, 0, 1, 1, 1, 0, 0, 0, 8'h04);
        check("up4_count", count, 8'h04);
        check("up4_dir", {7'b0, dir}, 8'h01);

        // Wrap both ways.
        do_load(8'hFF);
        check("load_ff", count, 8'hFF);
        drive(1, 0, 1, 1, 1, 1, 0, 0, 8'h00);
        drive(0, 0, 1, 1, 0, 0, 1, 0, 8'hFF);
        check("wrap_dir", {7'b0, dir}, 8'h00);

        // Two-cycle glitch on A is filtered out.
        enc_a = 1'b1;
        repeat (2) @(negedge clk);
        enc_a = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_count", count, 8'hFF);

        // Illegal double transition, then a legal edge from the new state.
        drive(1, 1, 1, 0, 0, 0, 0, 1, 8'hFF);
        drive(0, 1, 1, 1, 1, 1, 0, 0, 8'h00);

        // syn_clr and load coincide with the update edge of a decoded step.
        do_load(8'h33);
        check("load_33", count, 8'h33);
        c0 = cyc;
        enc_a = 1'b0; enc_b = 1'b0;
        while (cyc < c0 + LAT - 1) @(negedge clk);
        syn_clr = 1'b1; load = 1'b1; in_num = 8'h55;
        @(negedge clk);
        syn_clr = 1'b0; load = 1'b0;
        repeat (4) @(negedge clk);
        check("clr_load_step_count", count, 8'h00);

        // Steps ignored while disabled, counted again once enabled.
        enable = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 8'h00);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 8'h00);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        check("disabled_count", count, 8'h00);
        enable = 1'b1;
        drive(1, 0, 1, 1, 1, 0, 0, 0, 8'h01);
        check("reenable_count", count, 8'h01);

        repeat (5) @(negedge clk);
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL pending_events got=%0d want=0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
